// File: rtl/axis_src_pkg.sv
// Shared definitions for the AXI-Stream packet source: data pattern modes,
// FSM states and the 32-bit Fibonacci LFSR used for pseudo-random payloads.
package axis_src_pkg;

    // Data pattern selector; the reserved code 2'b11 falls back to incrementing
    typedef enum logic [1:0] {
        MODE_INCR  = 2'b00,
        MODE_LFSR  = 2'b01,
        MODE_CONST = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam int LFSR_WIDTH = 32;

    // Feedback taps of the Fibonacci register (bit indices into r)
    localparam int LFSR_TAP_A = 31;
    localparam int LFSR_TAP_B = 21;
    localparam int LFSR_TAP_C = 1;
    localparam int LFSR_TAP_D = 0;

    // One shift of the register: shift left, feed the XOR of the taps into bit 0
    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] r);
        return {r[LFSR_WIDTH-2:0],
                r[LFSR_TAP_A] ^ r[LFSR_TAP_B] ^ r[LFSR_TAP_C] ^ r[LFSR_TAP_D]};
    endfunction

    // The all-zero state is a lock-up state, so a zero seed is replaced by 1
    function automatic logic [LFSR_WIDTH-1:0] lfsr_load_value(input logic [LFSR_WIDTH-1:0] seed);
        return (seed == '0) ? LFSR_WIDTH'(1) : seed;
    endfunction

endpackage

// File: rtl/axis_packet_source_if.sv
// AXI-Stream bundle between a stream master and a stream sink.
interface axis_packet_source_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (
        output tdata,
        output tstrb,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tstrb,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/axis_lfsr32.sv
// 32-bit Fibonacci LFSR with load and advance controls. Load wins over
// advance; a zero seed loads as 1 so the register can never lock up.
module axis_lfsr32
    import axis_src_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [LFSR_WIDTH-1:0] seed,
    input  logic                  advance,
    output logic [LFSR_WIDTH-1:0] value
);

    logic [LFSR_WIDTH-1:0] r_q;

    // Shift register: reload on a new run, step once per consumed beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= LFSR_WIDTH'(1);
        end else if (load) begin
            r_q <= lfsr_load_value(seed);
        end else if (advance) begin
            r_q <= lfsr_step(r_q);
        end
    end

    assign value = r_q;

endmodule

// File: rtl/axis_packet_source.sv
// AXI-Stream traffic source: emits cfg_pkt_count packets of cfg_pkt_len
// beats with incrementing, LFSR or constant payload, separated by
// GAP_CYCLES idle cycles. Every output comes straight from a flop, and the
// next-state of those flops is computed from state_d so that tvalid/busy/done
// line up with the state the FSM is entering.
module axis_packet_source
    import axis_src_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 12,
    parameter int CNT_WIDTH  = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    m00_axis_aclk,
    input  logic                    m00_axis_areset,
    input  logic                    start,
    input  logic [1:0]              cfg_mode,
    input  logic [DATA_WIDTH-1:0]   cfg_seed,
    input  logic [LEN_WIDTH-1:0]    cfg_pkt_len,
    input  logic [CNT_WIDTH-1:0]    cfg_pkt_count,
    input  logic [DATA_WIDTH/8-1:0] cfg_last_strb,
    axis_packet_source_if.master    m00_axis,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    pkt_sent
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // FSM
    state_e state_q, state_d;
    logic   launch;
    logic   hs;
    logic   last_beat;
    logic   last_pkt;
    logic   pkt_done;

    // Configuration captured at launch
    mode_e                  mode_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic [STRB_WIDTH-1:0]  strb_q;
    logic [STRB_WIDTH-1:0]  strb_eff;

    // Counters
    logic [LEN_WIDTH-1:0]   beat_q, beat_d;
    logic [LEN_WIDTH-1:0]   len_d;
    logic [CNT_WIDTH-1:0]   pkt_sent_q, pkt_sent_d;
    logic [GAP_W-1:0]       gap_q, gap_d;

    // Payload generation
    logic [LFSR_WIDTH-1:0]  seed32;
    logic [LFSR_WIDTH-1:0]  lfsr_value;
    logic [LFSR_WIDTH-1:0]  lfsr_first32;
    logic [LFSR_WIDTH-1:0]  lfsr_next32;
    logic [DATA_WIDTH-1:0]  lfsr_first_data;
    logic [DATA_WIDTH-1:0]  lfsr_next_data;
    logic [DATA_WIDTH-1:0]  data_d;

    // Output register stage
    logic [DATA_WIDTH-1:0]  tdata_q;
    logic [STRB_WIDTH-1:0]  tstrb_q, tstrb_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    assign hs        = tvalid_q & m00_axis.tready;
    assign last_beat = (beat_q == len_q - LEN_WIDTH'(1));
    assign last_pkt  = (pkt_sent_q == count_q - CNT_WIDTH'(1));
    assign strb_eff  = (cfg_last_strb == '0) ? '1 : cfg_last_strb;

    // Match the 32-bit LFSR to the stream width: zero-extend or truncate
    generate
        if (DATA_WIDTH > LFSR_WIDTH) begin : g_wide
            assign seed32          = cfg_seed[LFSR_WIDTH-1:0];
            assign lfsr_first_data = {{(DATA_WIDTH-LFSR_WIDTH){1'b0}}, lfsr_first32};
            assign lfsr_next_data  = {{(DATA_WIDTH-LFSR_WIDTH){1'b0}}, lfsr_next32};
        end else if (DATA_WIDTH == LFSR_WIDTH) begin : g_equal
            assign seed32          = cfg_seed;
            assign lfsr_first_data = lfsr_first32;
            assign lfsr_next_data  = lfsr_next32;
        end else begin : g_narrow
            assign seed32          = {{(LFSR_WIDTH-DATA_WIDTH){1'b0}}, cfg_seed};
            assign lfsr_first_data = lfsr_first32[DATA_WIDTH-1:0];
            assign lfsr_next_data  = lfsr_next32[DATA_WIDTH-1:0];
        end
    endgenerate

    assign lfsr_first32 = lfsr_load_value(seed32);
    assign lfsr_next32  = lfsr_step(lfsr_value);

    axis_lfsr32 u_lfsr (
        .clk     (m00_axis_aclk),
        .rst     (m00_axis_areset),
        .load    (launch),
        .seed    (seed32),
        .advance (hs),
        .value   (lfsr_value)
    );

    // State register
    always_ff @(posedge m00_axis_aclk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (m00_axis_areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the launch / packet-complete strobes
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
        state_d  = state_q;
        launch   = 1'b0;
        pkt_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (cfg_pkt_len != '0) && (cfg_pkt_count != '0)) begin
                    launch  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (hs && last_beat) begin
                    pkt_done = 1'b1;
                    if (last_pkt) begin
                        state_d = DONE;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = SEND;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = SEND;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Counter and payload next values, plus the output values for the next cycle
    always_comb begin
        beat_d     = beat_q;
        len_d      = launch ? cfg_pkt_len : len_q;
        pkt_sent_d = pkt_sent_q;
        gap_d      = '0;
        data_d     = tdata_q;

        if (launch) begin
            beat_d     = '0;
            pkt_sent_d = '0;
        end else if (hs) begin
            beat_d = last_beat ? '0 : beat_q + LEN_WIDTH'(1);
            if (pkt_done) begin
                pkt_sent_d = pkt_sent_q + CNT_WIDTH'(1);
            end
        end

        if (state_q == GAP) begin
            gap_d = gap_q + GAP_W'(1);
        end

        if (launch) begin
            data_d = (mode_e'(cfg_mode) == MODE_LFSR) ? lfsr_first_data : cfg_seed;
        end else if (hs) begin
            case (mode_q)
                MODE_LFSR:  data_d = lfsr_next_data;
                MODE_CONST: data_d = tdata_q;
                default:    data_d = tdata_q + DATA_WIDTH'(1);
            endcase
        end

        tvalid_d = (state_d == SEND);
        busy_d   = (state_d == SEND) || (state_d == GAP);
        done_d   = (state_d == DONE);
        tlast_d  = tvalid_d && (beat_d == len_d - LEN_WIDTH'(1));
        if (!tvalid_d) begin
            tstrb_d = '0;
        end else if (tlast_d) begin
            tstrb_d = launch ? strb_eff : strb_q;
        end else begin
            tstrb_d = '1;
        end
    end

    // Configuration capture, counters and the registered output stage
    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            mode_q     <= MODE_INCR;
            len_q      <= '0;
            count_q    <= '0;
            strb_q     <= '0;
            beat_q     <= '0;
            pkt_sent_q <= '0;
            gap_q      <= '0;
            tdata_q    <= '0;
            tstrb_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (launch) begin
                mode_q  <= mode_e'(cfg_mode);
                len_q   <= cfg_pkt_len;
                count_q <= cfg_pkt_count;
                strb_q  <= strb_eff;
            end
            beat_q     <= beat_d;
            pkt_sent_q <= pkt_sent_d;
            gap_q      <= gap_d;
            tdata_q    <= data_d;
            tstrb_q    <= tstrb_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign m00_axis.tdata  = tdata_q;
    assign m00_axis.tstrb  = tstrb_q;
    assign m00_axis.tvalid = tvalid_q;
    assign m00_axis.tlast  = tlast_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pkt_sent        = pkt_sent_q;

endmodule

// File: tb/tb_axis_packet_source.sv
// Directed testbench for axis_packet_source: incrementing, backpressure,
// LFSR, multi-packet with gap, ignored starts and reset mid-packet.
module tb_axis_packet_source;

    localparam int DW  = 32;
    localparam int LW  = 12;
    localparam int CW  = 16;
    localparam int GAP = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    cfg_mode = 2'b00;
    logic [DW-1:0] cfg_seed = '0;
    logic [LW-1:0] cfg_pkt_len = '0;
    logic [CW-1:0] cfg_pkt_count = '0;
    logic [3:0]    cfg_last_strb = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] pkt_sent;

    axis_packet_source_if #(.DATA_WIDTH(DW)) axis ();

    axis_packet_source #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .CNT_WIDTH  (CW),
        .GAP_CYCLES (GAP)
    ) dut (
        .m00_axis_aclk   (clk),
        .m00_axis_areset (rst),
        .start           (start),
        .cfg_mode        (cfg_mode),
        .cfg_seed        (cfg_seed),
        .cfg_pkt_len     (cfg_pkt_len),
        .cfg_pkt_count   (cfg_pkt_count),
        .cfg_last_strb   (cfg_last_strb),
        .m00_axis        (axis),
        .busy            (busy),
        .done            (done),
        .pkt_sent        (pkt_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Capture of beats seen by the sink
    logic [DW-1:0] cap_data [32];
    logic [3:0]    cap_strb [32];
    logic          cap_last [32];
    int            cap_n;
    int            cap_cycles;
    int            gap_len [8];
    int            gap_n;
    int            stall_bad;
    int            drop_bad;
    int            bubble_bad;
    bit            timeout;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [1:0] mode, input logic [DW-1:0] seed,
                             input logic [LW-1:0] len, input logic [CW-1:0] count,
                             input logic [3:0] strb);
        cfg_mode      = mode;
        cfg_seed      = seed;
        cfg_pkt_len   = len;
        cfg_pkt_count = count;
        cfg_last_strb = strb;
    endtask

    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Drive tready (always 1, or 0,1,0,1...) and record n handshaked beats.
    // Ends in the cycle after the last handshake.
    task automatic collect(input int n, input bit alt);
        int            cyc = 0;
        int            cur_gap = 0;
        bit            prev_stall = 1'b0;
        bit            prev_hs_mid = 1'b0;
        logic [DW-1:0] hd = '0;
        logic [3:0]    hst = '0;
        logic          hl = 1'b0;
        cap_n = 0; gap_n = 0; stall_bad = 0; drop_bad = 0; bubble_bad = 0; timeout = 1'b0;
        while (cap_n < n) begin
            if (cyc >= 200) begin
                timeout = 1'b1;
                break;
            end
            axis.tready = alt ? cyc[0] : 1'b1;
            if (prev_stall) begin
                if (!axis.tvalid) drop_bad++;
                else if (axis.tdata !== hd || axis.tstrb !== hst || axis.tlast !== hl) stall_bad++;
            end
            if (prev_hs_mid && !axis.tvalid) bubble_bad++;
            if (axis.tvalid) begin
                if (cur_gap > 0 && gap_n < 8) begin
                    gap_len[gap_n] = cur_gap;
                    gap_n++;
                end
                cur_gap = 0;
            end else if (cap_n > 0) begin
                cur_gap++;
            end
            prev_stall  = axis.tvalid && !axis.tready;
            prev_hs_mid = axis.tvalid && axis.tready && !axis.tlast;
            hd = axis.tdata; hst = axis.tstrb; hl = axis.tlast;
            if (axis.tvalid && axis.tready && cap_n < 32) begin
                cap_data[cap_n] = axis.tdata;
                cap_strb[cap_n] = axis.tstrb;
                cap_last[cap_n] = axis.tlast;
                cap_n++;
            end
            step();
            cyc++;
        end
        cap_cycles  = cyc;
        axis.tready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        axis.tready = 1'b1;
        step();
        step();
        checks++;
        if ({axis.tdata, axis.tstrb, axis.tvalid, axis.tlast} !== '0) begin
            errors++;
            $display("FAIL reset_stream got tdata=%h tstrb=%h tvalid=%b tlast=%b want all 0",
                     axis.tdata, axis.tstrb, axis.tvalid, axis.tlast);
        end
        checks++;
        if ({busy, done, pkt_sent} !== '0) begin
            errors++;
            $display("FAIL reset_status got busy=%b done=%b pkt_sent=%0d want 0 0 0", busy, done, pkt_sent);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_incr();
        configure(2'b00, 32'h10, 12'd4, 16'd1, 4'h0);
        launch();
        checks++;
        if (axis.tvalid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL incr_latency got tvalid=%b busy=%b want 1 1", axis.tvalid, busy);
        end
        collect(4, 1'b0);
        checks++;
        if (timeout || cap_cycles !== 4) begin
            errors++;
            $display("FAIL incr_cycles got %0d cycles (timeout=%b) want 4", cap_cycles, timeout);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_data[i] !== 32'h10 + i || cap_strb[i] !== 4'hF || cap_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL incr_beat%0d got %h/%h/%b want %h/f/%b",
                         i, cap_data[i], cap_strb[i], cap_last[i], 32'h10 + i, (i == 3));
            end
        end
        checks++;
        if (done !== 1'b1 || axis.tvalid !== 1'b0 || busy !== 1'b0 || pkt_sent !== 16'd1) begin
            errors++;
            $display("FAIL incr_done got done=%b tvalid=%b busy=%b pkt_sent=%0d want 1 0 0 1",
                     done, axis.tvalid, busy, pkt_sent);
        end
        step();
        checks++;
        if (done !== 1'b0 || pkt_sent !== 16'd1) begin
            errors++;
            $display("FAIL incr_after got done=%b pkt_sent=%0d want 0 1", done, pkt_sent);
        end
    endtask

    task automatic test_backpressure();
        configure(2'b00, 32'h10, 12'd4, 16'd1, 4'h0);
        launch();
        collect(4, 1'b1);
        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL bp_timeout got %0d beats want 4", cap_n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_data[i] !== 32'h10 + i || cap_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL bp_beat%0d got %h/%b want %h/%b", i, cap_data[i], cap_last[i], 32'h10 + i, (i == 3));
            end
        end
        checks++;
        if (stall_bad !== 0 || drop_bad !== 0 || bubble_bad !== 0) begin
            errors++;
            $display("FAIL bp_stability got unstable=%0d drops=%0d bubbles=%0d want 0 0 0",
                     stall_bad, drop_bad, bubble_bad);
        end
        checks++;
        if (done !== 1'b1 || pkt_sent !== 16'd1) begin
            errors++;
            $display("FAIL bp_done got done=%b pkt_sent=%0d want 1 1", done, pkt_sent);
        end
        step();
    endtask

    task automatic test_lfsr();
        logic [DW-1:0] exp_l [3];
        exp_l[0] = 32'h1; exp_l[1] = 32'h3; exp_l[2] = 32'h6;
        for (int s = 0; s < 2; s++) begin
            configure(2'b01, (s == 0) ? 32'h1 : 32'h0, 12'd3, 16'd1, 4'h0);
            launch();
            collect(3, 1'b0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (timeout || cap_data[i] !== exp_l[i] || cap_last[i] !== (i == 2)) begin
                    errors++;
                    $display("FAIL lfsr_seed%0d_beat%0d got %h/%b want %h/%b",
                             1 - s, i, cap_data[i], cap_last[i], exp_l[i], (i == 2));
                end
            end
            step();
        end
    endtask

    task automatic test_multi_gap();
        configure(2'b00, 32'h0, 12'd2, 16'd3, 4'h3);
        launch();
        collect(6, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (timeout || cap_data[i] !== i || cap_last[i] !== (i % 2 == 1) ||
                cap_strb[i] !== ((i % 2 == 1) ? 4'h3 : 4'hF)) begin
                errors++;
                $display("FAIL gap_beat%0d got %h/%h/%b want %h/%h/%b", i, cap_data[i], cap_strb[i],
                         cap_last[i], i, (i % 2 == 1) ? 4'h3 : 4'hF, (i % 2 == 1));
            end
        end
        checks++;
        if (gap_n !== 2 || gap_len[0] !== GAP || gap_len[1] !== GAP) begin
            errors++;
            $display("FAIL gap_idle got gaps=%0d len0=%0d len1=%0d want 2 2 2", gap_n, gap_len[0], gap_len[1]);
        end
        checks++;
        if (done !== 1'b1 || pkt_sent !== 16'd3) begin
            errors++;
            $display("FAIL gap_done got done=%b pkt_sent=%0d want 1 3", done, pkt_sent);
        end
        step();
    endtask

    task automatic test_ignored_start();
        configure(2'b00, 32'h100, 12'd4, 16'd1, 4'h0);
        launch();
        // Pulse start with a different config while the first beat transfers
        configure(2'b10, 32'h999, 12'd1, 16'd5, 4'h1);
        launch();
        collect(3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (timeout || cap_data[i] !== 32'h101 + i || cap_last[i] !== (i == 2)) begin
                errors++;
                $display("FAIL busy_start_beat%0d got %h/%b want %h/%b",
                         i, cap_data[i], cap_last[i], 32'h101 + i, (i == 2));
            end
        end
        checks++;
        if (done !== 1'b1 || pkt_sent !== 16'd1) begin
            errors++;
            $display("FAIL busy_start_done got done=%b pkt_sent=%0d want 1 1", done, pkt_sent);
        end
        step();
        for (int z = 0; z < 2; z++) begin
            configure(2'b00, 32'h5, (z == 0) ? 12'd0 : 12'd4, (z == 0) ? 16'd3 : 16'd0, 4'h0);
            launch();
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (busy !== 1'b0 || axis.tvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL zero_cfg%0d_cycle%0d got busy=%b tvalid=%b want 0 0", z, c, busy, axis.tvalid);
                end
                step();
            end
        end
    endtask

    task automatic test_reset_mid();
        configure(2'b00, 32'h40, 12'd4, 16'd1, 4'h0);
        launch();
        step();
        checks++;
        if (axis.tvalid !== 1'b1 || axis.tdata !== 32'h41) begin
            errors++;
            $display("FAIL rst_mid_beat2 got tvalid=%b tdata=%h want 1 41", axis.tvalid, axis.tdata);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({axis.tdata, axis.tstrb, axis.tvalid, axis.tlast, busy, done, pkt_sent} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs got tdata=%h tstrb=%h tvalid=%b tlast=%b busy=%b done=%b pkt_sent=%0d want all 0",
                     axis.tdata, axis.tstrb, axis.tvalid, axis.tlast, busy, done, pkt_sent);
        end
        rst = 1'b0;
        step();
        step();
        checks++;
        if (axis.tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle got tvalid=%b busy=%b want 0 0", axis.tvalid, busy);
        end
        launch();
        checks++;
        if (axis.tdata !== 32'h40 || pkt_sent !== 16'd0 || axis.tvalid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_restart got tdata=%h pkt_sent=%0d tvalid=%b want 40 0 1",
                     axis.tdata, pkt_sent, axis.tvalid);
        end
        collect(4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (timeout || cap_data[i] !== 32'h40 + i) begin
                errors++;
                $display("FAIL rst_mid_beat%0d got %h want %h", i, cap_data[i], 32'h40 + i);
            end
        end
        checks++;
        if (done !== 1'b1 || pkt_sent !== 16'd1) begin
            errors++;
            $display("FAIL rst_mid_done got done=%b pkt_sent=%0d want 1 1", done, pkt_sent);
        end
        step();
    endtask

    initial begin
        axis.tready = 1'b1;
        test_reset();
        test_incr();
        test_backpressure();
        test_lfsr();
        test_multi_gap();
        test_ignored_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
